// File: rtl/bellek_asamasi_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// A request is a valid/ready handshake; a read response is a one-cycle valid pulse.
interface bellek_asamasi_if;
    logic        vb_istek_gecerli_o;
    logic        vb_istek_hazir_i;
    logic        vb_yaz_etkin_o;
    logic [31:0] vb_adres_o;
    logic [31:0] vb_yaz_veri_o;
    logic [3:0]  vb_yaz_maske_o;
    logic        vb_cevap_gecerli_i;
    logic [31:0] vb_cevap_veri_i;

    modport master (
        output vb_istek_gecerli_o,
        output vb_yaz_etkin_o,
        output vb_adres_o,
        output vb_yaz_veri_o,
        output vb_yaz_maske_o,
        input  vb_istek_hazir_i,
        input  vb_cevap_gecerli_i,
        input  vb_cevap_veri_i
    );

    modport slave (
        input  vb_istek_gecerli_o,
        input  vb_yaz_etkin_o,
        input  vb_adres_o,
        input  vb_yaz_veri_o,
        input  vb_yaz_maske_o,
        output vb_istek_hazir_i,
        output vb_cevap_gecerli_i,
        output vb_cevap_veri_i
    );
endinterface

// File: rtl/bellek_asamasi.sv
// Memory-access pipeline stage: turns the ALU result into a data-memory access or
// passes it through, steers store lanes, extends load data and stalls upstream
// while an access is outstanding. The writeback result is registered.
module bellek_asamasi (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              yurut_gecerli_i,
    input  logic [31:0]       amb_sonuc_i,
    input  logic              bellek_oku_i,
    input  logic              bellek_yaz_i,
    input  logic [2:0]        buyruk_turu_i,
    input  logic [31:0]       yaz_verisi_i,
    input  logic [4:0]        hedef_yazmac_i,
    input  logic              yazmaca_yaz_i,
    output logic              durdur_o,
    bellek_asamasi_if.master  vb,
    output logic              gy_gecerli_o,
    output logic [31:0]       gy_sonuc_o,
    output logic [4:0]        gy_hedef_o,
    output logic              gy_yazmaca_yaz_o,
    output logic              hizasiz_o
);
    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] ISTEK = 2'd1;
    localparam logic [1:0] CEVAP = 2'd2;

    logic [1:0]  durum_q, durum_d;

    // Latched request, held stable for the whole access
    logic [31:0] adres_q;
    logic [31:0] veri_q;
    logic [3:0]  maske_q;
    logic        yaz_q;
    logic [2:0]  tur_q;
    logic [4:0]  hedef_q;
    logic        yy_q;

    logic        gy_gecerli_q, gy_gecerli_d;
    logic [31:0] gy_sonuc_q, gy_sonuc_d;
    logic [4:0]  gy_hedef_q, gy_hedef_d;
    logic        gy_yy_q, gy_yy_d;
    logic        hizasiz_q, hizasiz_d;

    logic        bellek_op;
    logic        hizasiz;
    logic        istek_yukle;
    logic [31:0] veri_d;
    logic [3:0]  maske_d;
    logic [31:0] kayik;
    logic [31:0] yuk_veri;

    assign bellek_op = bellek_oku_i | bellek_yaz_i;

    // Alignment check by access size; unlisted sizes are treated as words
    always_comb begin
        case (buyruk_turu_i[1:0])
            2'b00:   hizasiz = 1'b0;
            2'b01:   hizasiz = amb_sonuc_i[0];
            default: hizasiz = (amb_sonuc_i[1:0] != 2'b00);
        endcase
    end

    // Store lane steering: replicate data across lanes, strobe only the addressed bytes
    always_comb begin
        case (buyruk_turu_i[1:0])
            2'b00: begin
                veri_d  = {4{yaz_verisi_i[7:0]}};
                maske_d = 4'b0001 << amb_sonuc_i[1:0];
            end
            2'b01: begin
                veri_d  = {2{yaz_verisi_i[15:0]}};
                maske_d = 4'b0011 << {amb_sonuc_i[1], 1'b0};
            end
            default: begin
                veri_d  = yaz_verisi_i;
                maske_d = 4'b1111;
            end
        endcase
    end

    // Load extraction: move the addressed lane to bit 0, then extend
    always_comb begin
        kayik = vb.vb_cevap_veri_i >> {adres_q[1:0], 3'b000};
        case (tur_q)
            3'b000:  yuk_veri = {{24{kayik[7]}}, kayik[7:0]};
            3'b100:  yuk_veri = {24'h0, kayik[7:0]};
            3'b001:  yuk_veri = {{16{kayik[15]}}, kayik[15:0]};
            3'b101:  yuk_veri = {16'h0, kayik[15:0]};
            default: yuk_veri = vb.vb_cevap_veri_i;
        endcase
    end

    // Stall until the completing cycle of an aligned memory op
    always_comb begin
        case (durum_q)
            BOSTA:   durdur_o = yurut_gecerli_i & bellek_op & ~hizasiz;
            ISTEK:   durdur_o = ~(yaz_q & vb.vb_istek_hazir_i);
            CEVAP:   durdur_o = ~vb.vb_cevap_gecerli_i;
            default: durdur_o = 1'b0;
        endcase
    end

    // Next state and next writeback entry
    always_comb begin
        durum_d      = durum_q;
        istek_yukle  = 1'b0;
        gy_gecerli_d = 1'b0;
        gy_sonuc_d   = gy_sonuc_q;
        gy_hedef_d   = gy_hedef_q;
        gy_yy_d      = gy_yy_q;
        hizasiz_d    = 1'b0;
        case (durum_q)
            BOSTA: begin
                if (yurut_gecerli_i) begin
                    if (!bellek_op || hizasiz) begin
                        // Pass-through, or a misaligned access retired without touching memory
                        gy_gecerli_d = 1'b1;
                        gy_sonuc_d   = amb_sonuc_i;
                        gy_hedef_d   = hedef_yazmac_i;
                        gy_yy_d      = yazmaca_yaz_i & ~bellek_op;
                        hizasiz_d    = bellek_op;
                    end else begin
                        istek_yukle = 1'b1;
                        durum_d     = ISTEK;
                    end
                end
            end
            ISTEK: begin
                if (vb.vb_istek_hazir_i) begin
                    if (yaz_q) begin
                        gy_gecerli_d = 1'b1;
                        gy_sonuc_d   = adres_q;
                        gy_hedef_d   = hedef_q;
                        gy_yy_d      = 1'b0;
                        durum_d      = BOSTA;
                    end else begin
                        durum_d = CEVAP;
                    end
                end
            end
            CEVAP: begin
                if (vb.vb_cevap_gecerli_i) begin
                    gy_gecerli_d = 1'b1;
                    gy_sonuc_d   = yuk_veri;
                    gy_hedef_d   = hedef_q;
                    gy_yy_d      = yy_q;
                    durum_d      = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    // State, request latch and writeback registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q      <= BOSTA;
            adres_q      <= 32'h0;
            veri_q       <= 32'h0;
            maske_q      <= 4'h0;
            yaz_q        <= 1'b0;
            tur_q        <= 3'h0;
            hedef_q      <= 5'h0;
            yy_q         <= 1'b0;
            gy_gecerli_q <= 1'b0;
            gy_sonuc_q   <= 32'h0;
            gy_hedef_q   <= 5'h0;
            gy_yy_q      <= 1'b0;
            hizasiz_q    <= 1'b0;
        end else begin
            durum_q      <= durum_d;
            gy_gecerli_q <= gy_gecerli_d;
            gy_sonuc_q   <= gy_sonuc_d;
            gy_hedef_q   <= gy_hedef_d;
            gy_yy_q      <= gy_yy_d;
            hizasiz_q    <= hizasiz_d;
            if (istek_yukle) begin
                adres_q <= amb_sonuc_i;
                veri_q  <= veri_d;
                maske_q <= maske_d;
                yaz_q   <= bellek_yaz_i;   // a store wins if both flags are set
                tur_q   <= buyruk_turu_i;
                hedef_q <= hedef_yazmac_i;
                yy_q    <= yazmaca_yaz_i;
            end
        end
    end

    assign vb.vb_istek_gecerli_o = (durum_q == ISTEK);
    assign vb.vb_yaz_etkin_o     = yaz_q;
    assign vb.vb_adres_o         = {adres_q[31:2], 2'b00};
    assign vb.vb_yaz_veri_o      = veri_q;
    assign vb.vb_yaz_maske_o     = maske_q;

    assign gy_gecerli_o     = gy_gecerli_q;
    assign gy_sonuc_o       = gy_sonuc_q;
    assign gy_hedef_o       = gy_hedef_q;
    assign gy_yazmaca_yaz_o = gy_yy_q;
    assign hizasiz_o        = hizasiz_q;
endmodule

// File: tb/tb_bellek_asamasi.sv
// Bench for bellek_asamasi: table of operations with bus-side checks, a writeback
// scoreboard, and hand-written reset-during-access sequences.
module tb_bellek_asamasi;
    logic        clk;
    logic        rst;
    logic        yurut_gecerli;
    logic [31:0] amb_sonuc;
    logic        bellek_oku;
    logic        bellek_yaz;
    logic [2:0]  buyruk_turu;
    logic [31:0] yaz_verisi;
    logic [4:0]  hedef_yazmac;
    logic        yazmaca_yaz;
    logic        durdur;
    logic        gy_gecerli;
    logic [31:0] gy_sonuc;
    logic [4:0]  gy_hedef;
    logic        gy_yazmaca_yaz;
    logic        hizasiz;

    bellek_asamasi_if vb ();

    bellek_asamasi dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .yurut_gecerli_i  (yurut_gecerli),
        .amb_sonuc_i      (amb_sonuc),
        .bellek_oku_i     (bellek_oku),
        .bellek_yaz_i     (bellek_yaz),
        .buyruk_turu_i    (buyruk_turu),
        .yaz_verisi_i     (yaz_verisi),
        .hedef_yazmac_i   (hedef_yazmac),
        .yazmaca_yaz_i    (yazmaca_yaz),
        .durdur_o         (durdur),
        .vb               (vb),
        .gy_gecerli_o     (gy_gecerli),
        .gy_sonuc_o       (gy_sonuc),
        .gy_hedef_o       (gy_hedef),
        .gy_yazmaca_yaz_o (gy_yazmaca_yaz),
        .hizasiz_o        (hizasiz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        oku;
        logic        yaz;
        logic [2:0]  f3;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [4:0]  hedef;
        logic        yy;
        int          hwait;
        int          rwait;
        logic [31:0] rdata;
        logic [31:0] exp_sonuc;
        logic [31:0] exp_adres;
        logic [31:0] exp_veri;
        logic [3:0]  exp_maske;
        logic        exp_hiz;
    } vec_t;

    typedef struct {
        logic [31:0] sonuc;
        logic        chk_sonuc;
        logic [4:0]  hedef;
        logic        yy;
        logic        hiz;
    } beklenen_t;

    vec_t      tablo[$];
    beklenen_t sb[$];
    int        total = 0;
    int        bad = 0;
    int        hs_say = 0;

    task automatic check(input string ad, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", ad, got, want, $time);
        end
    endtask

    // Writeback monitor: every valid entry must match the oldest expectation
    always @(negedge clk) begin
        if (vb.vb_istek_gecerli_o && vb.vb_istek_hazir_i) hs_say++;
        if (gy_gecerli) begin
            if (sb.size() == 0) begin
                check("gy_beklenmedik", 32'(gy_gecerli), 32'(0));
            end else begin
                beklenen_t b;
                b = sb.pop_front();
                if (b.chk_sonuc) check("gy_sonuc", gy_sonuc, b.sonuc);
                check("gy_hedef", 32'(gy_hedef), 32'(b.hedef));
                check("gy_yazmaca_yaz", 32'(gy_yazmaca_yaz), 32'(b.yy));
                check("hizasiz", 32'(hizasiz), 32'(b.hiz));
            end
        end else begin
            check("hizasiz_bos", 32'(hizasiz), 32'(0));
        end
    end

    task automatic girdileri_sifirla();
        yurut_gecerli = 1'b0;
        amb_sonuc     = 32'h0;
        bellek_oku    = 1'b0;
        bellek_yaz    = 1'b0;
        buyruk_turu   = 3'h0;
        yaz_verisi    = 32'h0;
        hedef_yazmac  = 5'h0;
        yazmaca_yaz   = 1'b0;
    endtask

    task automatic run(input vec_t v);
        logic      mem;
        int        hs0;
        beklenen_t b;
        mem = (v.oku | v.yaz) & ~v.exp_hiz;
        @(posedge clk); #1;
        yurut_gecerli = 1'b1;
        amb_sonuc     = v.adr;
        bellek_oku    = v.oku;
        bellek_yaz    = v.yaz;
        buyruk_turu   = v.f3;
        yaz_verisi    = v.wdata;
        hedef_yazmac  = v.hedef;
        yazmaca_yaz   = v.yy;
        b.sonuc     = v.exp_sonuc;
        b.chk_sonuc = ~v.yaz & ~v.exp_hiz;
        b.hedef     = v.hedef;
        b.yy        = v.yy & ~v.yaz & ~v.exp_hiz;
        b.hiz       = v.exp_hiz;
        sb.push_back(b);
        hs0 = hs_say;
        @(negedge clk);
        check("durdur_kabul", 32'(durdur), 32'(mem));
        check("istek_kabul", 32'(vb.vb_istek_gecerli_o), 32'(0));
        @(posedge clk); #1;
        if (mem) begin
            for (int i = 0; i <= v.hwait; i++) begin
                vb.vb_istek_hazir_i = (i == v.hwait);
                @(negedge clk);
                check("istek_gecerli", 32'(vb.vb_istek_gecerli_o), 32'(1));
                check("vb_adres", vb.vb_adres_o, v.exp_adres);
                check("vb_yaz_etkin", 32'(vb.vb_yaz_etkin_o), 32'(v.yaz));
                if (v.yaz) begin
                    check("vb_yaz_veri", vb.vb_yaz_veri_o, v.exp_veri);
                    check("vb_yaz_maske", 32'(vb.vb_yaz_maske_o), 32'(v.exp_maske));
                end
                check("durdur_istek", 32'(durdur), 32'(!(v.yaz && i == v.hwait)));
                @(posedge clk); #1;
            end
            vb.vb_istek_hazir_i = 1'b0;
            if (!v.yaz) begin
                for (int j = 0; j <= v.rwait; j++) begin
                    vb.vb_cevap_gecerli_i = (j == v.rwait);
                    vb.vb_cevap_veri_i    = (j == v.rwait) ? v.rdata : 32'h5A5A5A5A;
                    @(negedge clk);
                    check("istek_cevapta", 32'(vb.vb_istek_gecerli_o), 32'(0));
                    check("durdur_cevap", 32'(durdur), 32'(j != v.rwait));
                    @(posedge clk); #1;
                end
                vb.vb_cevap_gecerli_i = 1'b0;
            end
        end
        girdileri_sifirla();
        @(negedge clk);
        check("gecikme_gy", 32'(gy_gecerli), 32'(1));
        check("el_sikisma", 32'(hs_say - hs0), 32'(mem));
    endtask

    initial begin
        #200000;
        $display("FAIL zaman_asimi: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hs0;
        //          oku   yaz   f3      adr           wdata         hed   yy    hw rw rdata         sonuc         adres         veri          maske    hiz
        tablo.push_back('{1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0,        5'd5, 1'b1, 0, 0, 32'h0,        32'h12345678, 32'h0,        32'h0,        4'b0000, 1'b0});
        tablo.push_back('{1'b0, 1'b1, 3'b000, 32'h00001003, 32'h000000A5, 5'd3, 1'b1, 0, 0, 32'h0,        32'h0,        32'h00001000, 32'hA5A5A5A5, 4'b1000, 1'b0});
        tablo.push_back('{1'b1, 1'b0, 3'b000, 32'h00002002, 32'h0,        5'd7, 1'b1, 0, 3, 32'h00800000, 32'hFFFFFF80, 32'h00002000, 32'h0,        4'b0000, 1'b0});
        tablo.push_back('{1'b1, 1'b0, 3'b100, 32'h00002002, 32'h0,        5'd7, 1'b1, 0, 3, 32'h00800000, 32'h00000080, 32'h00002000, 32'h0,        4'b0000, 1'b0});
        tablo.push_back('{1'b0, 1'b1, 3'b010, 32'h00000040, 32'hDEADBEEF, 5'd0, 1'b0, 4, 0, 32'h0,        32'h0,        32'h00000040, 32'hDEADBEEF, 4'b1111, 1'b0});
        tablo.push_back('{1'b1, 1'b0, 3'b010, 32'h00003001, 32'h0,        5'd8, 1'b1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 1'b1});
        tablo.push_back('{1'b0, 1'b1, 3'b001, 32'h00002006, 32'h0000BEEF, 5'd0, 1'b0, 1, 0, 32'h0,        32'h0,        32'h00002004, 32'hBEEFBEEF, 4'b1100, 1'b0});
        tablo.push_back('{1'b1, 1'b0, 3'b001, 32'h00000100, 32'h0,        5'd10,1'b1, 0, 0, 32'h12348001, 32'hFFFF8001, 32'h00000100, 32'h0,        4'b0000, 1'b0});
        tablo.push_back('{1'b1, 1'b0, 3'b101, 32'h00000102, 32'h0,        5'd11,1'b1, 1, 2, 32'h87654321, 32'h00008765, 32'h00000100, 32'h0,        4'b0000, 1'b0});
        tablo.push_back('{1'b0, 1'b1, 3'b001, 32'h00000011, 32'h00001234, 5'd0, 1'b0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 1'b1});
        tablo.push_back('{1'b1, 1'b0, 3'b010, 32'h00000200, 32'h0,        5'd12,1'b1, 2, 0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h00000200, 32'h0,        4'b0000, 1'b0});
        tablo.push_back('{1'b1, 1'b0, 3'b000, 32'h00000201, 32'h0,        5'd13,1'b1, 0, 1, 32'h00007F00, 32'h0000007F, 32'h00000200, 32'h0,        4'b0000, 1'b0});
        tablo.push_back('{1'b1, 1'b1, 3'b000, 32'h00000001, 32'h00000012, 5'd14,1'b1, 0, 0, 32'h0,        32'h0,        32'h00000000, 32'h12121212, 4'b0010, 1'b0});
        tablo.push_back('{1'b1, 1'b0, 3'b010, 32'h00000300, 32'h0,        5'd15,1'b0, 0, 1, 32'h01020304, 32'h01020304, 32'h00000300, 32'h0,        4'b0000, 1'b0});
        tablo.push_back('{1'b1, 1'b0, 3'b011, 32'h00000304, 32'h0,        5'd16,1'b1, 0, 0, 32'hA5A50F0F, 32'hA5A50F0F, 32'h00000304, 32'h0,        4'b0000, 1'b0});
        tablo.push_back('{1'b1, 1'b0, 3'b010, 32'h00003002, 32'h0,        5'd17,1'b1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000, 1'b1});
        tablo.push_back('{1'b0, 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0,        5'd31,1'b0, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        4'b0000, 1'b0});

        rst = 1'b1;
        girdileri_sifirla();
        vb.vb_istek_hazir_i   = 1'b0;
        vb.vb_cevap_gecerli_i = 1'b0;
        vb.vb_cevap_veri_i    = 32'h0;
        #12;
        check("rst_durdur", 32'(durdur), 32'(0));
        check("rst_istek", 32'(vb.vb_istek_gecerli_o), 32'(0));
        check("rst_adres", vb.vb_adres_o, 32'h0);
        check("rst_veri", vb.vb_yaz_veri_o, 32'h0);
        check("rst_maske", 32'(vb.vb_yaz_maske_o), 32'(0));
        check("rst_gy_gecerli", 32'(gy_gecerli), 32'(0));
        check("rst_gy_sonuc", gy_sonuc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tablo[k]) run(tablo[k]);

        // Reset while a store request is waiting for ready
        @(posedge clk); #1;
        hs0           = hs_say;
        yurut_gecerli = 1'b1;
        amb_sonuc     = 32'h00000080;
        bellek_yaz    = 1'b1;
        buyruk_turu   = 3'b010;
        yaz_verisi    = 32'h00000001;
        @(posedge clk); #1;
        @(negedge clk);
        check("istek_rst_oncesi", 32'(vb.vb_istek_gecerli_o), 32'(1));
        #2;
        rst = 1'b1;
        girdileri_sifirla();
        #1;
        check("istek_rst_hemen", 32'(vb.vb_istek_gecerli_o), 32'(0));
        check("istek_rst_durdur", 32'(durdur), 32'(0));
        check("istek_rst_adres", vb.vb_adres_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("istek_rst_hs", 32'(hs_say - hs0), 32'(0));

        // Reset while a load waits for its response, then a stale response
        @(posedge clk); #1;
        yurut_gecerli = 1'b1;
        amb_sonuc     = 32'h00000400;
        bellek_oku    = 1'b1;
        buyruk_turu   = 3'b010;
        hedef_yazmac  = 5'd9;
        yazmaca_yaz   = 1'b1;
        @(posedge clk); #1;
        vb.vb_istek_hazir_i = 1'b1;
        @(posedge clk); #1;
        vb.vb_istek_hazir_i = 1'b0;
        @(negedge clk);
        check("cevap_bekle_durdur", 32'(durdur), 32'(1));
        #2;
        rst = 1'b1;
        girdileri_sifirla();
        #1;
        check("cevap_rst_durdur", 32'(durdur), 32'(0));
        check("cevap_rst_gy", 32'(gy_gecerli), 32'(0));
        check("cevap_rst_istek", 32'(vb.vb_istek_gecerli_o), 32'(0));
        check("cevap_rst_gy_sonuc", gy_sonuc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        vb.vb_cevap_gecerli_i = 1'b1;
        vb.vb_cevap_veri_i    = 32'h11111111;
        @(negedge clk);
        check("bayat_durdur", 32'(durdur), 32'(0));
        @(posedge clk); #1;
        vb.vb_cevap_gecerli_i = 1'b0;
        @(negedge clk);
        check("bayat_cevap_gy", 32'(gy_gecerli), 32'(0));
        run(tablo[0]);

        @(posedge clk);
        @(negedge clk);
        check("sb_bos", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
